// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_LUI,
    S_ALUWB,
    S_JAL,
    S_JALR,
    S_LINK,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_BRANCH  = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// Maps the IR opcode to the state that follows S_DECODE; flags unsupported opcodes.
module opcode_classifier
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output state_t     next_state,
  output logic       illegal
);

  // Pure decode of the major opcode field.
  always_comb begin
    next_state = S_TRAP;
    illegal    = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: next_state = S_MEMADR;
      OP_R:              next_state = S_EXEC_R;
      OP_I:              next_state = S_EXEC_I;
      OP_LUI:            next_state = S_LUI;
      OP_JAL:            next_state = S_JAL;
      OP_JALR:           next_state = S_JALR;
      OP_BRANCH:         next_state = S_BRANCH;
      default:           illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over one shared ALU and one unified memory port.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] src_a,
  output logic [1:0] src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       is_branch,
  output logic       retire,
  output logic       halted
);

  state_t state_q, state_d;
  state_t decode_next;
  logic   decode_illegal;

  opcode_classifier u_classifier (
    .opcode     (opcode),
    .next_state (decode_next),
    .illegal    (decode_illegal)
  );

  // State register; reset always lands in S_FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing; memory states hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!decode_illegal)      state_d = decode_next;
        else if (TRAP_ON_ILLEGAL) state_d = S_TRAP;
        else                      state_d = S_FETCH;
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_LINK;
      S_LINK:     state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode, with mem_ready / branch_cond gating and reset forcing all zero.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    src_a      = SRC_A_PC;
    src_b      = SRC_B_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALU_ADD;
    retire     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        src_a      = SRC_A_PC;
        src_b      = SRC_B_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Latches the branch/jal target into ALUOut.
        src_a  = SRC_A_OLDPC;
        src_b  = SRC_B_IMM;
        retire = decode_illegal && !TRAP_ON_ILLEGAL;
      end
      S_MEMADR: begin
        src_a = SRC_A_RS1;
        src_b = SRC_B_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        retire  = mem_ready;
      end
      S_EXEC_R: begin
        src_a  = SRC_A_RS1;
        src_b  = SRC_B_RS2;
        alu_op = ALU_FUNCT;
      end
      S_EXEC_I: begin
        src_a  = SRC_A_RS1;
        src_b  = SRC_B_IMM;
        alu_op = ALU_FUNCT;
      end
      S_LUI: begin
        src_a = SRC_A_ZERO;
        src_b = SRC_B_IMM;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link address.
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        src_a      = SRC_A_OLDPC;
        src_b      = SRC_B_FOUR;
      end
      S_JALR: begin
        src_a      = SRC_A_RS1;
        src_b      = SRC_B_IMM;
        result_src = RES_ALURES;
        pc_write   = 1'b1;
      end
      S_LINK: begin
        src_a = SRC_A_OLDPC;
        src_b = SRC_B_FOUR;
      end
      S_BRANCH: begin
        src_a      = SRC_A_RS1;
        src_b      = SRC_B_RS2;
        alu_op     = ALU_BRANCH;
        result_src = RES_ALUOUT;
        pc_write   = branch_cond;
        retire     = 1'b1;
      end
      S_TRAP:  halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      src_a      = 2'b00;
      src_b      = 2'b00;
      result_src = 2'b00;
      alu_op     = 2'b00;
      retire     = 1'b0;
      halted     = 1'b0;
    end
  end

  assign is_branch = (alu_op == ALU_BRANCH);

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multi-cycle RV32I variant of the core. It sequences the shared ALU, register file, instruction register and single unified memory port across FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. It drives the datapath mux selects, the write strobes and the isBranch input of the ALU decoder. It waits on a valid/ready memory handshake and halts on an illegal opcode.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an illegal opcode enters S_TRAP and halts; 0: it is retired as a NOP (DECODE -> FETCH).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
opcode  in  7  instr[6:0] from the instruction register
branch_cond  in  1  ALU compare result (1 = branch taken)
mem_ready  in  1  memory has completed the current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  request is a write
adr_src  out  1  address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR and OldPC
pc_write  out  1  load PC from result bus
reg_write  out  1  register file write enable
src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
src_b  out  2  00 rs2, 01 imm, 10 const 4
result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result
alu_op  out  2  00 ADD, 01 BRANCH, 10 FUNCT (decoded from funct3/funct7)
is_branch  out  1  equals (alu_op == BRANCH); drives the ALU decoder
retire  out  1  one-cycle pulse on the last cycle of each instruction
halted  out  1  sticky while in S_TRAP

Behaviour:
- Reset is synchronous. While reset is high, every output is 0 and the next state is S_FETCH. A reset asserted mid-instruction (including during a memory wait) abandons the instruction with no write strobes.
- Outputs are decoded from state (Moore). Three exceptions are gated combinationally: FETCH strobes are gated by mem_ready, MEM strobes are gated by mem_ready, and the BRANCH pc_write is gated by branch_cond.
- Default for every output in every state: 0 / 00.
- S_FETCH: mem_req=1, adr_src=0, src_a=PC, src_b=4, alu_op=ADD, result_src=ALU result.
  - While mem_ready=0, stay in S_FETCH with ir_write=0 and pc_write=0.
  - When mem_ready=1, assert ir_write=1 and pc_write=1, then go to S_DECODE.
- S_DECODE: src_a=OldPC, src_b=imm, alu_op=ADD (the branch/jal target is latched into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> S_MEMADR
  - 0110011 -> S_EXEC_R
  - 0010011 -> S_EXEC_I
  - 0110111 -> S_LUI
  - 1101111 -> S_JAL
  - 1100111 -> S_JALR
  - 1100011 -> S_BRANCH
  - anything else -> S_TRAP, or S_FETCH with retire=1 if TRAP_ON_ILLEGAL=0
- S_MEMADR: src_a=rs1, src_b=imm, ADD. Next state is S_MEMREAD for a load, S_MEMWRITE for a store.
- S_MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then go to S_MEMWB.
- S_MEMWB: result_src=mem data, reg_write=1, retire=1 -> S_FETCH.
- S_MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready, assert retire=1 and go to S_FETCH.
- S_EXEC_R: src_a=rs1, src_b=rs2, alu_op=FUNCT -> S_ALUWB.
- S_EXEC_I: src_a=rs1, src_b=imm, alu_op=FUNCT -> S_ALUWB.
- S_LUI: src_a=zero, src_b=imm, ADD -> S_ALUWB.
- S_ALUWB: result_src=ALUOut, reg_write=1, retire=1 -> S_FETCH.
- S_JAL: result_src=ALUOut (target), pc_write=1; src_a=OldPC, src_b=4, ADD -> S_ALUWB (link write).
- S_JALR: src_a=rs1, src_b=imm, ADD, result_src=ALU result, pc_write=1 (the datapath clears bit 0) -> S_LINK.
- S_LINK: src_a=OldPC, src_b=4, ADD -> S_ALUWB. rs1 is consumed before rd is written, so rd==rs1 is safe.
- S_BRANCH: src_a=rs1, src_b=rs2, alu_op=BRANCH, is_branch=1, result_src=ALUOut, pc_write=branch_cond, retire=1 -> S_FETCH.
- S_TRAP: halted=1, no other strobes, mem_req=0. Only reset exits it.
- Memory handshake:
  - mem_req is held with stable adr_src/mem_we until the cycle mem_ready=1.
  - mem_ready is ignored when mem_req=0.
  - A zero-wait memory (mem_ready tied 1) yields a fixed cycle count per instruction class:

| Class | Cycles |
|---|---|
| load | 5 |
| store | 4 |
| R / I / LUI | 4 |
| JAL | 4 |
| JALR | 5 |
| branch | 3 |

- retire asserts exactly once per instruction and never in the same cycle as reset.

Decomposition:
- Package ctrl_pkg holds:
  - the state_t enum
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_JAL, OP_JALR, OP_BRANCH)
  - the src_a/src_b/result_src/alu_op encodings
- One sub-module, opcode_classifier: combinational opcode -> next state after S_DECODE, plus an illegal flag.
- State register plus output decode stay in multicycle_controller.

Test Plan:
- Reset held 3 cycles mid-S_MEMREAD, then released -> all outputs 0 during reset; first post-reset cycle is S_FETCH with mem_req=1, adr_src=0; no reg_write is ever seen for the aborted load.
- add (0110011), mem_ready=1 -> 4 cycles FETCH/DECODE/EXEC_R/ALUWB; alu_op=10 in EXEC_R; reg_write=1 and retire=1 only in cycle 4.
- lw with mem_ready low for 3 cycles in S_MEMREAD -> mem_req and adr_src=1 stable for 4 cycles; S_MEMWB follows with result_src=01 and reg_write=1; 8 cycles total.
- beq (1100011) run twice, branch_cond=1 then 0 -> is_branch=1 and alu_op=01 in S_BRANCH; pc_write=1 in the first run, 0 in the second; 3 cycles each, retire=1 each.
- jalr (1100111) -> pc_write in S_JALR with result_src=10; S_LINK then S_ALUWB with reg_write=1; 5 cycles.
- Opcode 7'b1111111 -> with TRAP_ON_ILLEGAL=1, halted=1 from cycle 3 and mem_req stays 0 for 20 cycles; with TRAP_ON_ILLEGAL=0, retire=1 in cycle 2 and mem_req=1 again in cycle 3.
